// File: rtl/calc_seq_ctrl.sv
// Moore sequencer for the ratio/sine datapath: capture -> check -> divide -> serial capture -> multiply -> result.
// One start/ready handshake in, one valid/ready result out, with divisor-zero and divider-timeout error reporting.
module calc_seq_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int SER_BITS    = 10,
  parameter int MUL_LAT     = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       start_ready,
  input  logic       divisor_zero,
  output logic       cap_en,
  output logic       div_en,
  input  logic       div_ok,
  output logic       s2p_en,
  output logic       mul_en,
  output logic       y_load,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_SER   = 3'd4;
  localparam logic [2:0] S_MUL   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [1:0] E_NONE    = 2'b00;
  localparam logic [1:0] E_DIVZERO = 2'b01;
  localparam logic [1:0] E_TIMEOUT = 2'b10;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SER_LAST = CNT_W'(SER_BITS - 1);
  localparam logic [CNT_W-1:0] MUL_LAT_LAST = CNT_W'(MUL_LAT - 1);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       code, code_nxt;

  // One shared counter serves the divider timeout, the serial window and the multiplier window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
          code_nxt  = E_NONE;
        end
      end
      S_LOAD: begin
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        cnt_nxt = '0;
        if (divisor_zero) begin
          state_nxt = S_ERR;
          code_nxt  = E_DIVZERO;
        end else begin
          state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        // A result arriving on the last allowed cycle still counts as success.
        if (div_ok) begin
          state_nxt = S_SER;
          cnt_nxt   = '0;
        end else if (cnt == DIV_LAST) begin
          state_nxt = S_ERR;
          cnt_nxt   = '0;
          code_nxt  = E_TIMEOUT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_SER: begin
        if (cnt == SER_LAST) begin
          state_nxt = S_MUL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_MUL: begin
        if (cnt == MUL_LAT_LAST) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      code  <= E_NONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      code  <= code_nxt;
    end
  end

  // err_code stays visible after the ack so software can still read it while idle.
  assign start_ready = (state == S_IDLE);
  assign cap_en      = (state == S_LOAD);
  assign div_en      = (state == S_DIV);
  assign s2p_en      = (state == S_SER);
  assign mul_en      = (state == S_MUL);
  assign y_load      = (state == S_MUL) && (cnt == MUL_LAT_LAST);
  assign out_valid   = (state == S_DONE) || (state == S_ERR);
  assign err         = (state == S_ERR);
  assign err_code    = code;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: randomized transactions checked against
// per-transaction timing formulas (enable-window lengths, result latency, error codes).
module tb_calc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start_ready;
  logic       divisor_zero;
  logic       cap_en;
  logic       div_en;
  logic       div_ok;
  logic       s2p_en;
  logic       mul_en;
  logic       y_load;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic [1:0] err_code;
  logic       busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Per-transaction observations gathered by run_txn.
  int         r_cap, r_div, r_ser, r_mul, r_yl, r_yl_rel;
  int         r_valid_first, r_vcnt, r_sr, r_busy, r_done_rel;
  logic       r_err;
  logic [1:0] r_code, r_code_load, r_post_code;
  logic [2:0] r_st1, r_st2, r_st_valid;
  logic [5:0] r_post;
  bit         r_hung;

  calc_seq_ctrl #(
    .DIV_TIMEOUT(64),
    .SER_BITS   (10),
    .MUL_LAT    (4),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_ready (start_ready),
    .divisor_zero(divisor_zero),
    .cap_en      (cap_en),
    .div_en      (div_en),
    .div_ok      (div_ok),
    .s2p_en      (s2p_en),
    .mul_en      (mul_en),
    .y_load      (y_load),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err         (err),
    .err_code    (err_code),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one transaction from IDLE and plays the consumer/divider side.
  // n < 0 keeps div_ok low for the whole DIV window; ack_delay extra valid cycles before out_ready.
  task automatic run_txn(input bit dz, input int n, input int ack_delay, input bit noise);
    bit done;
    done = 1'b0;
    r_cap = 0; r_div = 0; r_ser = 0; r_mul = 0; r_yl = 0; r_yl_rel = -1;
    r_valid_first = -1; r_vcnt = 0; r_sr = 0; r_busy = 0; r_done_rel = -1;
    r_err = 1'b0; r_code = 2'b00; r_code_load = 2'b11; r_st1 = 3'd0; r_st2 = 3'd0;
    r_st_valid = 3'd0; r_hung = 1'b1;
    divisor_zero = dz;
    start        = 1'b1;
    out_ready    = 1'b0;
    div_ok       = noise ? 1'($urandom) : 1'b0;
    step();
    for (int rel = 1; rel <= 200; rel++) begin
      if (rel == 1) begin
        r_st1       = state_dbg;
        r_code_load = err_code;
      end
      if (rel == 2) r_st2 = state_dbg;
      if (cap_en) r_cap++;
      if (div_en) r_div++;
      if (s2p_en) r_ser++;
      if (mul_en) r_mul++;
      if (y_load) begin
        r_yl++;
        r_yl_rel = rel;
      end
      if (start_ready) r_sr++;
      if (busy) r_busy++;
      out_ready = 1'b0;
      if (out_valid) begin
        if (r_valid_first < 0) begin
          r_valid_first = rel;
          r_err         = err;
          r_code        = err_code;
          r_st_valid    = state_dbg;
        end
        r_vcnt++;
        if (r_vcnt > ack_delay) begin
          out_ready  = 1'b1;
          done       = 1'b1;
          r_done_rel = rel;
        end
      end
      start = noise ? 1'($urandom) : 1'b0;
      if (rel < 3)              div_ok = noise ? 1'($urandom) : 1'b0;
      else if (n < 0)           div_ok = 1'b0;
      else if (rel < 3 + n)     div_ok = 1'b0;
      else if (rel == 3 + n)    div_ok = 1'b1;
      else                      div_ok = noise ? 1'($urandom) : 1'b1;
      step();
      if (done) begin
        r_hung = 1'b0;
        break;
      end
    end
    start     = 1'b0;
    out_ready = 1'b0;
    div_ok    = 1'b0;
    r_post      = {start_ready, busy, out_valid, state_dbg};
    r_post_code = err_code;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; div_ok = 1'b1; out_ready = 1'b1; divisor_zero = 1'b1;
    repeat (3) step();
    checks++;
    if ({cap_en, div_en, s2p_en, mul_en, y_load, out_valid, err, busy} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b want 00000000",
               {cap_en, div_en, s2p_en, mul_en, y_load, out_valid, err, busy});
    end
    checks++;
    if ({start_ready, err_code, state_dbg} !== 6'b1_00_000) begin
      errors++;
      $display("[TB] FAIL reset_ready_state got %b want 100000", {start_ready, err_code, state_dbg});
    end
    rst = 1'b0; start = 1'b0; div_ok = 1'b0; out_ready = 1'b0; divisor_zero = 1'b0;
    step();
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_idle_hold got %b want 1", start_ready);
    end
  endtask

  task automatic test_nominal();
    run_txn(1'b0, 5, 0, 1'b1);
    checks++;
    if (r_hung) begin errors++; $display("[TB] FAIL nominal_complete got hung want done"); end
    checks++;
    if (r_cap !== 1 || r_st1 !== 3'd1 || r_st2 !== 3'd2) begin
      errors++;
      $display("[TB] FAIL nominal_load_check got cap=%0d st1=%0d st2=%0d want 1 1 2", r_cap, r_st1, r_st2);
    end
    checks++;
    if (r_div !== 6) begin errors++; $display("[TB] FAIL nominal_div_cycles got %0d want 6", r_div); end
    checks++;
    if (r_ser !== 10) begin errors++; $display("[TB] FAIL nominal_ser_cycles got %0d want 10", r_ser); end
    checks++;
    if (r_mul !== 4) begin errors++; $display("[TB] FAIL nominal_mul_cycles got %0d want 4", r_mul); end
    checks++;
    if (r_yl !== 1 || r_yl_rel !== 22) begin
      errors++;
      $display("[TB] FAIL nominal_y_load got count=%0d at=%0d want 1 at 22", r_yl, r_yl_rel);
    end
    checks++;
    if (r_valid_first !== 23 || r_vcnt !== 1) begin
      errors++;
      $display("[TB] FAIL nominal_out_valid got at=%0d len=%0d want 23 1", r_valid_first, r_vcnt);
    end
    checks++;
    if ({r_err, r_code, r_st_valid} !== 6'b0_00_110) begin
      errors++;
      $display("[TB] FAIL nominal_result got %b want 000110", {r_err, r_code, r_st_valid});
    end
    checks++;
    if (r_sr !== 0 || r_busy !== 23) begin
      errors++;
      $display("[TB] FAIL nominal_busy got ready=%0d busy=%0d want 0 23", r_sr, r_busy);
    end
    checks++;
    if (r_post !== 6'b100_000) begin
      errors++;
      $display("[TB] FAIL nominal_post_idle got %b want 100000", r_post);
    end
  endtask

  task automatic test_divisor_zero();
    run_txn(1'b1, 0, 0, 1'b1);
    checks++;
    if (r_hung || r_valid_first !== 3) begin
      errors++;
      $display("[TB] FAIL dz_latency got %0d want 3", r_valid_first);
    end
    checks++;
    if ({r_err, r_code, r_st_valid} !== 6'b1_01_111) begin
      errors++;
      $display("[TB] FAIL dz_result got %b want 101111", {r_err, r_code, r_st_valid});
    end
    checks++;
    if (r_div + r_ser + r_mul + r_yl !== 0) begin
      errors++;
      $display("[TB] FAIL dz_no_datapath got %0d enable cycles want 0", r_div + r_ser + r_mul + r_yl);
    end
    checks++;
    if (r_post !== 6'b100_000 || r_post_code !== 2'b01) begin
      errors++;
      $display("[TB] FAIL dz_code_held got post=%b code=%b want 100000 01", r_post, r_post_code);
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, -1, 0, 1'b1);
    checks++;
    if (r_code_load !== 2'b00) begin
      errors++;
      $display("[TB] FAIL timeout_code_cleared got %b want 00", r_code_load);
    end
    checks++;
    if (r_div !== 64) begin errors++; $display("[TB] FAIL timeout_div_cycles got %0d want 64", r_div); end
    checks++;
    if (r_hung || r_valid_first !== 67 || r_ser + r_mul + r_yl !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_latency got at=%0d tail=%0d want 67 0", r_valid_first, r_ser + r_mul + r_yl);
    end
    checks++;
    if ({r_err, r_code, r_st_valid} !== 6'b1_10_111) begin
      errors++;
      $display("[TB] FAIL timeout_result got %b want 110111", {r_err, r_code, r_st_valid});
    end
    checks++;
    if (r_post !== 6'b100_000) begin
      errors++;
      $display("[TB] FAIL timeout_post_idle got %b want 100000", r_post);
    end
  endtask

  task automatic test_ack_hold();
    int n;
    n = int'($urandom_range(0, 8));
    run_txn(1'b0, n, 20, 1'b1);
    checks++;
    if (r_code_load !== 2'b00) begin
      errors++;
      $display("[TB] FAIL hold_code_cleared got %b want 00", r_code_load);
    end
    checks++;
    if (r_hung || r_valid_first !== n + 18 || r_vcnt !== 21) begin
      errors++;
      $display("[TB] FAIL hold_valid got at=%0d len=%0d want %0d 21", r_valid_first, r_vcnt, n + 18);
    end
    checks++;
    if (r_sr !== 0 || r_busy !== n + 38) begin
      errors++;
      $display("[TB] FAIL hold_busy got ready=%0d busy=%0d want 0 %0d", r_sr, r_busy, n + 38);
    end
    checks++;
    if (r_post !== 6'b100_000) begin
      errors++;
      $display("[TB] FAIL hold_post_idle got %b want 100000", r_post);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    n   = int'($urandom_range(0, 4));
    bad = 0;
    divisor_zero = 1'b0; out_ready = 1'b1; div_ok = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int rel = 1; rel <= 6 + n; rel++) begin
      if (y_load || out_valid) bad++;
      div_ok = (rel >= 3 + n);
      if (rel < 6 + n) step();
    end
    checks++;
    if (s2p_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_in_ser got %b want 1", s2p_en);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({start_ready, cap_en, div_en, s2p_en, mul_en, y_load, out_valid, err, busy, err_code, state_dbg}
        !== 14'b1_00000000_00_000) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs got %b want 10000000000000",
               {start_ready, cap_en, div_en, s2p_en, mul_en, y_load, out_valid, err, busy, err_code, state_dbg});
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL rstmid_no_result got %0d want 0", bad); end
    rst = 1'b0; out_ready = 1'b0; div_ok = 1'b0;
    step();
    run_txn(1'b0, 0, 0, 1'b0);
    checks++;
    if (r_hung || r_valid_first !== 18 || r_yl_rel !== 17 || r_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_restart got at=%0d yl=%0d err=%b want 18 17 0", r_valid_first, r_yl_rel, r_err);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int p;
    int idles;
    int errs_seen;
    int vt[$];
    n = int'($urandom_range(0, 6));
    p = 19 + n;
    idles = 0;
    errs_seen = 0;
    vt.delete();
    divisor_zero = 1'b0; start = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4 * p; c++) begin
      if (out_valid) begin
        vt.push_back(c);
        if (err) errs_seen++;
      end
      if (start_ready) idles++;
      div_ok = ((c % p) >= 3 + n);
      step();
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_final_idle got %b want 1", start_ready);
    end
    start = 1'b0; out_ready = 1'b0; div_ok = 1'b0;
    step();
    checks++;
    if (vt.size() !== 4 || idles !== 4 || errs_seen !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_counts got valid=%0d idle=%0d err=%0d want 4 4 0", vt.size(), idles, errs_seen);
    end
    for (int k = 0; k < vt.size(); k++) begin
      checks++;
      if (vt[k] !== k * p + p - 1) begin
        errors++;
        $display("[TB] FAIL b2b_valid_time[%0d] got %0d want %0d", k, vt[k], k * p + p - 1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      bit dz;
      bit to;
      int n;
      int ack;
      int exp_first;
      int exp_div;
      int exp_ser;
      int exp_mul;
      int exp_yl;
      logic [1:0] exp_code;
      dz  = ($urandom_range(0, 3) == 0);
      to  = !dz && ($urandom_range(0, 7) == 0);
      n   = to ? -1 : int'($urandom_range(0, 10));
      ack = int'($urandom_range(0, 3));
      exp_first = dz ? 3 : (to ? 3 + 64 : n + 4 + 10 + 4);
      exp_div   = dz ? 0 : (to ? 64 : n + 1);
      exp_ser   = (dz || to) ? 0 : 10;
      exp_mul   = (dz || to) ? 0 : 4;
      exp_yl    = (dz || to) ? 0 : 1;
      exp_code  = dz ? 2'b01 : (to ? 2'b10 : 2'b00);
      run_txn(dz, n, ack, 1'b1);
      checks++;
      if (r_hung || r_valid_first !== exp_first || r_vcnt !== ack + 1) begin
        errors++;
        $display("[TB] FAIL rand%0d_valid got at=%0d len=%0d want %0d %0d",
                 i, r_valid_first, r_vcnt, exp_first, ack + 1);
      end
      checks++;
      if (r_div !== exp_div || r_ser !== exp_ser || r_mul !== exp_mul || r_yl !== exp_yl) begin
        errors++;
        $display("[TB] FAIL rand%0d_windows got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 i, r_div, r_ser, r_mul, r_yl, exp_div, exp_ser, exp_mul, exp_yl);
      end
      checks++;
      if ({r_err, r_code} !== {(dz || to), exp_code} || r_code_load !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rand%0d_code got err=%b code=%b load=%b want %b %b 00",
                 i, r_err, r_code, r_code_load, (dz || to), exp_code);
      end
      checks++;
      if (r_post !== 6'b100_000 || r_post_code !== exp_code) begin
        errors++;
        $display("[TB] FAIL rand%0d_post got %b code=%b want 100000 %b", i, r_post, r_post_code, exp_code);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; div_ok = 1'b0; out_ready = 1'b0; divisor_zero = 1'b0;
    test_reset();
    test_nominal();
    test_divisor_zero();
    test_timeout();
    test_ack_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
